// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-attached arithmetic engine.
package uart_alu_pkg;

  typedef enum logic [7:0] {
    OpAdd  = 8'hA0,
    OpMul  = 8'hA1,
    OpDiv  = 8'hA2,
    OpEcho = 8'hEC
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StRsv,
    StLenLo,
    StLenHi,
    StPayload,
    StExec,
    StResp
  } parse_state_e;

  localparam logic [15:0] HeaderLen = 16'd4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling.
module uart_rx #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  rx_state_e       state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            bit_end;

  assign bit_end = (cnt_q == CntW'(ClksPerBit - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      valid_o   <= 1'b0;
      cnt_q     <= cnt_q + 1'b1;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) state_q <= StStart;
        end
        // A start bit that is no longer low at mid-bit was a glitch.
        StStart: begin
          if (cnt_q == CntW'(ClksPerBit / 2 - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? StIdle : StData;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (rx_sync_q) begin
              data_o  <= shift_q;
              valid_o <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a 1-entry holding register for back-to-back frames.
module uart_tx #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);

  logic [9:0]      frame_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_q;
  logic            busy_q;
  logic [7:0]      hold_q;
  logic            hold_full_q;
  logic            bit_end, frame_end, load;

  assign bit_end   = (cnt_q == CntW'(ClksPerBit - 1));
  assign frame_end = busy_q && bit_end && (bit_q == 4'd9);
  // Reload on the last stop-bit cycle so consecutive frames have no idle gap.
  assign load      = hold_full_q && (!busy_q || frame_end);
  assign ready_o   = !hold_full_q;
  assign txd_o     = frame_q[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q     <= '1;
      cnt_q       <= '0;
      bit_q       <= '0;
      busy_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (load) begin
        frame_q     <= {1'b1, hold_q, 1'b0};
        busy_q      <= 1'b1;
        cnt_q       <= '0;
        bit_q       <= '0;
        hold_full_q <= 1'b0;
      end else if (busy_q) begin
        if (bit_end) begin
          cnt_q   <= '0;
          frame_q <= {1'b1, frame_q[9:1]};
          bit_q   <= bit_q + 4'd1;
          if (bit_q == 4'd9) busy_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (valid_i && !hold_full_q) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_alu.sv
// Packet parser and ALU: decodes framed commands from RX, executes echo/add/mul/div,
// and streams result bytes to TX.
module uart_alu
  import uart_alu_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic txd_o
);

  localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD_RATE;

  logic [7:0]   rx_data, tx_data;
  logic         rx_valid, tx_valid, tx_ready;
  parse_state_e state_q;
  logic [7:0]   opcode_q;
  logic [15:0]  len_q, byte_cnt_q, len_full, pay_idx;
  logic [31:0]  op_a_q, op_b_q, result_q, rem_q, quot_q;
  logic [4:0]   div_cnt_q;
  logic         div_busy_q;
  logic [1:0]   resp_idx_q;
  logic [32:0]  div_trial, div_diff;
  logic         is_alu;

  uart_rx #(.ClksPerBit(ClksPerBit)) u_rx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rxd_i  (rxd_i),
    .data_o (rx_data),
    .valid_o(rx_valid)
  );

  uart_tx #(.ClksPerBit(ClksPerBit)) u_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (tx_data),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .txd_o  (txd_o)
  );

  assign len_full  = {rx_data, len_q[7:0]};
  assign pay_idx   = byte_cnt_q - HeaderLen;
  assign is_alu    = (opcode_q == OpAdd) || (opcode_q == OpMul) || (opcode_q == OpDiv);
  assign div_trial = {rem_q, quot_q[31]};
  assign div_diff  = div_trial - {1'b0, op_b_q};

  // Echo bytes bypass the ALU; the holding register absorbs them at equal baud.
  assign tx_valid = ((state_q == StResp) && tx_ready) ||
                    ((state_q == StPayload) && rx_valid && (opcode_q == OpEcho));
  assign tx_data  = (state_q == StResp) ? result_q[8*resp_idx_q +: 8] : rx_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      opcode_q   <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      div_cnt_q  <= '0;
      div_busy_q <= 1'b0;
      resp_idx_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_valid) begin
            opcode_q <= rx_data;
            state_q  <= StRsv;
          end
        end
        StRsv: if (rx_valid) state_q <= StLenLo;
        StLenLo: begin
          if (rx_valid) begin
            len_q[7:0] <= rx_data;
            state_q    <= StLenHi;
          end
        end
        StLenHi: begin
          if (rx_valid) begin
            len_q[15:8] <= rx_data;
            byte_cnt_q  <= HeaderLen;
            state_q     <= (len_full > HeaderLen) ? StPayload : StIdle;
          end
        end
        StPayload: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
            if (pay_idx < 16'd4) op_a_q[8*pay_idx[1:0] +: 8] <= rx_data;
            else if (pay_idx < 16'd8) op_b_q[8*pay_idx[1:0] +: 8] <= rx_data;
            if (byte_cnt_q + 16'd1 == len_q) begin
              state_q <= (is_alu && (len_q >= 16'd12)) ? StExec : StIdle;
            end
          end
        end
        StExec: begin
          if (opcode_q == OpDiv) begin
            if (!div_busy_q) begin
              div_busy_q <= 1'b1;
              rem_q      <= '0;
              quot_q     <= op_a_q;
              div_cnt_q  <= '0;
            end else begin
              // Restoring step; a zero divisor naturally yields all-ones.
              rem_q     <= div_diff[32] ? div_trial[31:0] : div_diff[31:0];
              quot_q    <= {quot_q[30:0], ~div_diff[32]};
              div_cnt_q <= div_cnt_q + 5'd1;
              if (div_cnt_q == 5'd31) begin
                div_busy_q <= 1'b0;
                result_q   <= {quot_q[30:0], ~div_diff[32]};
                resp_idx_q <= '0;
                state_q    <= StResp;
              end
            end
          end else begin
            result_q   <= (opcode_q == OpAdd) ? op_a_q + op_b_q : op_a_q * op_b_q;
            resp_idx_q <= '0;
            state_q    <= StResp;
          end
        end
        StResp: begin
          if (tx_ready) begin
            resp_idx_q <= resp_idx_q + 2'd1;
            if (resp_idx_q == 2'd3) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu.sv
// Bench for uart_alu: serial packet driver, TX frame monitor and a packet-level reference model.
module tb_uart_alu;

  localparam int unsigned Cpb = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  always #5 clk = ~clk;

  uart_alu #(.CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rxd_i(rxd),
    .txd_o(txd)
  );

  typedef struct {
    logic [7:0] b;
    bit         contig;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] pkt[$];
  int         checks = 0;
  int         failures = 0;
  string      cur_name = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s/%s actual=%h required=%h", cur_name, name, act, req);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      8'hA0: return a + b;
      8'hA1: return p[31:0];
      8'hA2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void push_exp(input logic [7:0] b, input bit contig);
    exp_t e;
    e.b = b;
    e.contig = contig;
    expq.push_back(e);
  endfunction

  // Expected response for the whole packet in pkt, from the packet rules alone.
  function automatic void predict();
    int len;
    logic [31:0] a, b, r;
    len = int'({pkt[3], pkt[2]});
    if (len <= 4) return;
    if (pkt[0] == 8'hEC) begin
      for (int i = 4; i < len; i++) push_exp(pkt[i], 1'b0);
    end else if ((pkt[0] == 8'hA0 || pkt[0] == 8'hA1 || pkt[0] == 8'hA2) && len >= 12) begin
      a = {pkt[7], pkt[6], pkt[5], pkt[4]};
      b = {pkt[11], pkt[10], pkt[9], pkt[8]};
      r = alu_model(pkt[0], a, b);
      for (int i = 0; i < 4; i++) push_exp(r[8*i +: 8], i != 0);
    end
  endfunction

  // TX monitor: decodes frames at mid-bit and compares against the expected queue.
  int         mon_cnt = 0;
  int         mon_gap = 0;
  bit         mon_busy = 1'b0;
  logic [7:0] mon_byte;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
      mon_cnt  = 0;
      mon_gap  = 0;
    end else if (!mon_busy) begin
      mon_gap++;
      if (txd !== 1'b1) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        if (expq.size() > 0 && expq[0].contig) check("tx_gap", mon_gap, Cpb / 2);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % Cpb == Cpb / 2) begin
        if (mon_cnt / Cpb == 0) begin
          check("tx_start_bit", txd, 1'b0);
        end else if (mon_cnt / Cpb <= 8) begin
          mon_byte[mon_cnt / Cpb - 1] = txd;
        end else begin
          check("tx_stop_bit", txd, 1'b1);
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s/unexpected_tx actual=%h required=none", cur_name, mon_byte);
          end else begin
            mon_e = expq.pop_front();
            check("tx_byte", mon_byte, mon_e.b);
          end
          mon_busy = 1'b0;
          mon_gap  = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = good;
    repeat (Cpb) @(negedge clk);
    if (!good) begin
      rxd = 1'b1;
      repeat (Cpb) @(negedge clk);
    end
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], 1'b1);
  endtask

  task automatic build_alu_pkt(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'h00);
    pkt.push_back(8'd12);
    pkt.push_back(8'h00);
    for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) pkt.push_back(b[8*i +: 8]);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((expq.size() != 0 || mon_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("pending_bytes", expq.size(), 0);
    expq.delete();
    repeat (2 * Cpb) @(negedge clk);
  endtask

  task automatic run_alu(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r);
    cur_name = name;
    check("model_pin", alu_model(op, a, b), exp_r);
    build_alu_pkt(op, a, b);
    for (int i = 0; i < 4; i++) push_exp(exp_r[8*i +: 8], i != 0);
    send_pkt();
    wait_done();
  endtask

  initial begin
    bit   bad;
    int   n, len, sel, r;
    logic [7:0] op;

    repeat (5) @(negedge clk);
    check("txd_in_reset", txd, 1'b1);
    rst = 1'b0;
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1) bad = 1'b1;
    end
    check("idle_after_reset", bad, 1'b0);

    cur_name = "echo";
    build_alu_pkt(8'hEC, 32'd5, 32'd0);
    push_exp(8'h05, 1'b0);
    for (int i = 0; i < 7; i++) push_exp(8'h00, 1'b0);
    send_pkt();
    wait_done();

    run_alu("add", 8'hA0, 32'd5, 32'd7, 32'h0000_000C);
    run_alu("add_wrap", 8'hA0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    run_alu("mul", 8'hA1, 32'd3, 32'd4, 32'h0000_000C);
    run_alu("mul_max", 8'hA1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_alu("div", 8'hA2, 32'd15, 32'd3, 32'h0000_0005);
    run_alu("div_zero", 8'hA2, 32'd1234, 32'd0, 32'hFFFF_FFFF);

    // Unknown opcode consumed silently, then a normal ADD.
    cur_name = "unknown";
    build_alu_pkt(8'h55, 32'hDEAD_BEEF, 32'h1234_5678);
    send_pkt();
    run_alu("add_after_unknown", 8'hA0, 32'd1, 32'd2, 32'h0000_0003);

    // Framing errors: one idle-time byte and one mid-packet byte are both discarded.
    cur_name = "framing";
    build_alu_pkt(8'hA0, 32'h0000_0010, 32'h0000_0020);
    push_exp(8'h30, 1'b0);
    for (int i = 0; i < 3; i++) push_exp(8'h00, 1'b1);
    send_byte(8'h3C, 1'b0);
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i], 1'b1);
      if (i == 5) send_byte(8'hAA, 1'b0);
    end
    wait_done();

    // Reset during an ADD response.
    cur_name = "reset_mid_resp";
    build_alu_pkt(8'hA0, 32'd5, 32'd7);
    push_exp(8'h0C, 1'b0);
    send_pkt();
    n = 0;
    while (txd === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("resp_started", txd, 1'b0);
    repeat (3 * Cpb) @(negedge clk);
    rst = 1'b1;
    #1;
    check("txd_at_reset", txd, 1'b1);
    expq.delete();
    repeat (4) @(negedge clk);
    check("txd_held_in_reset", txd, 1'b1);
    rst = 1'b0;
    repeat (2 * Cpb) @(negedge clk);
    run_alu("add_after_reset", 8'hA0, 32'd1, 32'd2, 32'h0000_0003);

    // Randomized packets against the model.
    for (int k = 0; k < 6; k++) begin
      cur_name = $sformatf("rand%0d", k);
      sel = $urandom_range(0, 4);
      case (sel)
        0: op = 8'hEC;
        1: op = 8'hA0;
        2: op = 8'hA1;
        3: op = 8'hA2;
        default: op = 8'(8'h10 + $urandom_range(0, 8'h4F));
      endcase
      r = $urandom_range(0, 9);
      if (r < 5) len = 12;
      else if (r < 7) len = $urandom_range(13, 16);
      else if (r == 7) len = $urandom_range(5, 11);
      else len = $urandom_range(0, 4);
      pkt.delete();
      pkt.push_back(op);
      pkt.push_back(8'h00);
      pkt.push_back(8'(len));
      pkt.push_back(8'h00);
      for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
      if (op == 8'hA2 && len >= 12 && $urandom_range(0, 1) == 1) begin
        pkt[8]  = 8'($urandom_range(1, 20));
        pkt[9]  = 8'h00;
        pkt[10] = 8'h00;
        pkt[11] = 8'h00;
      end
      predict();
      send_pkt();
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_alu.md
# uart_alu

UART-attached arithmetic engine: receives framed command packets on a serial RX line, executes echo, add, multiply or divide on 32-bit operands, and returns the result bytes on a serial TX line. It is the top-level design block exercised by the `uart_runner` bench harness. The harness wraps this block as `dut` and drives it through `reset()` and `send_uart_packet(opcode, a, b)`.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: core clock frequency.
- `BAUD_RATE`, default 115_200: serial bit rate. Simulation may override it. Clocks per bit = `CLK_FREQ_HZ / BAUD_RATE`, which must be ≥ 16.
- `clk_i` input 1: single clock. All logic is on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `rxd_i` input 1: serial receive. Idle high, 8N1, LSB first. Asynchronous to `clk_i`.
- `txd_o` output 1: serial transmit. Idle high, 8N1, LSB first.

## Operation
- **Packet layout** (byte order): opcode, reserved (0x00), length LSB, length MSB, payload.
  - Length is the total packet byte count, including the 4-byte header.
  - Operands are 32-bit little-endian.
  - `send_uart_packet` sends length = 12 (operand A, then operand B).
- **Opcodes**:
  - 0xEC ECHO: every payload byte is retransmitted unchanged, in order. Example: A=5, B=0 returns 05 00 00 00 00 00 00 00.
  - 0xA0 ADD: result = A + B, mod 2^32.
  - 0xA1 MUL: result = low 32 bits of the unsigned A × B.
  - 0xA2 DIV: result = unsigned A / B, truncated. B = 0 gives 0xFFFF_FFFF.
  - ALU ops return 4 result bytes, little-endian.
- **Length handling**:
  - ALU ops use the first two operands; further payload bytes are consumed and ignored.
  - ALU length < 12: the packet is consumed, no response.
  - Length < 4: treated as a header-only packet, no response.
- **Unknown opcode**: the packet is consumed per its length field; no response.
- **Parser FSM** states: IDLE → RSV → LEN_LO → LEN_HI → PAYLOAD → EXEC → RESP → IDLE.
  - ECHO forwards bytes to TX during PAYLOAD, then returns to IDLE.
  - Any byte received during EXEC/RESP is dropped. The bench waits for the response before sending again.
- **Receiver**:
  - 2-flop synchronizer on `rxd_i`.
  - Start-bit edge detection; the start bit is revalidated at mid-bit, and data bits are sampled at mid-bit.
  - A stop bit sampled low is a framing error: that byte is discarded and the parser state is unchanged.
- **Transmitter**: start bit, 8 data bits LSB first, stop bit, each held exactly clocks-per-bit cycles. A 1-entry holding register decouples it from the parser. Echo cannot overflow it because RX and TX share the same baud.

## Timing
- **Reset**:
  - `txd_o` = 1; all FSMs to IDLE; counters and operand registers cleared.
  - Reset asserted mid-frame aborts both RX and TX immediately. A truncated TX frame is acceptable.
  - After release, the block idles until a start bit arrives.
- **ALU latency**:
  - ADD and MUL: result registered 1 cycle after the last operand byte is accepted.
  - DIV: iterative restoring divider, 32 cycles plus 1.
  - TX start bit begins ≤ 2 cycles after the result is registered.
- **ECHO latency**: each byte's TX start bit begins ≤ 2 cycles after that byte's RX stop-bit sample.
- **Response framing**: response bytes are sent back-to-back, with no idle bits between frames.
- **Boundary conditions**:
  - Length-field wrap is not supported; the maximum is 65535.
  - 0xFFFF_FFFF + 1 = 0.
  - 0xFFFF_FFFF × 0xFFFF_FFFF = 0x0000_0001.

## Structure
- **Shared package `uart_alu_pkg`**:
  - Opcode enum: ECHO = 0xEC, ADD = 0xA0, MUL = 0xA1, DIV = 0xA2.
  - Parser state enum.
  - Header length constant: 4.
- **Sub-modules**:
  - `uart_rx` and `uart_tx`, both parameterized by clocks-per-bit.
  - The divider stays inline in the top-level.
- **Size**: roughly 250–350 lines of RTL in total.

## Test plan
- Reset, then idle: `txd_o` stays 1 for 1000 cycles after `rst_i` is released.
- ECHO 0xEC, A=0x5, B=0x0 → TX returns 05 00 00 00 00 00 00 00.
- ADD 0xA0, A=5, B=7 → TX 0C 00 00 00. Also A=0xFFFF_FFFF, B=1 → 00 00 00 00.
- MUL 0xA1, A=3, B=4 → TX 0C 00 00 00.
- DIV 0xA2, A=15, B=3 → TX 05 00 00 00. Also B=0 → FF FF FF FF.
- Unknown opcode 0x55 with length 12, followed by ADD 1+2 → no response to the first packet; TX 03 00 00 00 for the second. Reset asserted mid-ADD-response → `txd_o` = 1 at once, and the next packet is handled normally.
